// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-master external memory bus arbiter for IF and MEM ports
module mem_bus_arbiter #(
    parameter int TIMEOUT        = 16,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,

    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,

    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } state_t;

    // Counter widths leave headroom so the limits are always representable.
    localparam int              TCW   = $clog2(TIMEOUT + 2);
    localparam int              SCW   = $clog2(MEM_STREAK_MAX + 2);
    localparam bit              TO_EN = (TIMEOUT != 0);
    localparam logic [TCW-1:0]  TLIM  = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SCW-1:0]  SMAX  = SCW'(MEM_STREAK_MAX);

    state_t          r_state;
    state_t          w_state_next;
    logic [TCW-1:0]  r_tcnt;
    logic [SCW-1:0]  r_streak;

    logic            r_bus_req;
    logic            r_bus_we;
    logic [3:0]      r_bus_sel;
    logic [31:0]     r_bus_addr;
    logic [31:0]     r_bus_wdata;
    logic [31:0]     r_if_rdata;
    logic [31:0]     r_mem_rdata;
    logic            r_if_done;
    logic            r_mem_done;
    logic            r_bus_err;

    logic            w_if_elig;
    logic            w_mem_elig;
    logic            w_grant_if;
    logic            w_grant_mem;
    logic            w_finish;
    logic            w_abort;

    // A requester is ignored during its own done cycle; its req is still high then.
    assign w_if_elig  = if_req  & ~r_if_done;
    assign w_mem_elig = mem_req & ~r_mem_done;

    // Next-state and grant/completion decode.
    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_mem  = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_elig && !(w_if_elig && (r_streak == SMAX))) begin
                    w_grant_mem  = 1'b1;
                    w_state_next = ST_BUSY_MEM;
                end else if (w_if_elig) begin
                    w_grant_if   = 1'b1;
                    w_state_next = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_MEM: begin
                // Ready on the limit cycle takes priority over the abort.
                if (bus_ready) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (TO_EN && (r_tcnt == TLIM)) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus launch, response capture, timeout and starvation bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_if_rdata  <= 32'h0;
            r_mem_rdata <= 32'h0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_tcnt      <= '0;
            r_streak    <= '0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_grant_mem) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_we;
                r_bus_sel   <= mem_sel;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= mem_wdata;
                r_tcnt      <= '0;
                if (w_if_elig) begin
                    r_streak <= (r_streak == SMAX) ? r_streak : r_streak + SCW'(1);
                end else begin
                    r_streak <= '0;
                end
            end else if (w_grant_if) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= 4'hF;
                r_bus_addr  <= if_addr;
                r_bus_wdata <= 32'h0;
                r_tcnt      <= '0;
                r_streak    <= '0;
            end else if (w_finish) begin
                r_bus_req <= 1'b0;
                if (r_state == ST_BUSY_IF) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= bus_rdata;
                end else begin
                    r_mem_done  <= 1'b1;
                    r_mem_rdata <= bus_rdata;
                end
            end else if (w_abort) begin
                r_bus_req <= 1'b0;
                r_bus_err <= 1'b1;
                if (r_state == ST_BUSY_IF) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= 32'h0;
                end else begin
                    r_mem_done  <= 1'b1;
                    r_mem_rdata <= 32'h0;
                end
            end else if (r_state != ST_IDLE) begin
                r_tcnt <= r_tcnt + TCW'(1);
            end
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_sel      = r_bus_sel;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign if_rdata     = r_if_rdata;
    assign mem_rdata    = r_mem_rdata;
    assign if_done      = r_if_done;
    assign mem_done     = r_mem_done;
    assign bus_err      = r_bus_err;
    assign stallreq_if  = if_req  & ~r_if_done;
    assign stallreq_mem = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ready = 1'b0;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          busy;
    int          ng;
    logic        got_done;
    logic        if_seen;
    logic [31:0] g [8];

    mem_bus_arbiter #(.TIMEOUT(16), .MEM_STREAK_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready    (bus_ready),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus_req",   bus_req,   0);
        check("rst_bus_we",    bus_we,    0);
        check("rst_bus_sel",   bus_sel,   0);
        check("rst_bus_addr",  bus_addr,  0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_if_done",   if_done,   0);
        check("rst_mem_done",  mem_done,  0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_bus_err",   bus_err,   0);
        rst = 1'b1;

        // Lone IF read
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        #1 check("if_stall_on", stallreq_if, 1);
        @(negedge clk);
        check("if_bus_req",  bus_req,  1);
        check("if_bus_addr", bus_addr, 32'h100);
        check("if_bus_we",   bus_we,   0);
        check("if_bus_sel",  bus_sel,  4'hF);
        check("if_done_early", if_done, 0);
        check("if_stall_busy", stallreq_if, 1);
        bus_ready = 1'b1; bus_rdata = 32'h24010005;
        @(negedge clk);
        check("if_done",      if_done,     1);
        check("if_rdata",     if_rdata,    32'h24010005);
        check("if_stall_off", stallreq_if, 0);
        check("if_bus_drop",  bus_req,     0);
        check("if_no_err",    bus_err,     0);
        bus_ready = 1'b0; bus_rdata = 32'h0; if_req = 1'b0;
        @(negedge clk);
        check("if_done_pulse", if_done, 0);

        // Simultaneous IF and MEM store: MEM first, then IF after the done cycle
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h2000; mem_wdata = 32'hABCD;
        @(negedge clk);
        check("sim_bus_addr",  bus_addr,  32'h2000);
        check("sim_bus_we",    bus_we,    1);
        check("sim_bus_sel",   bus_sel,   4'b0011);
        check("sim_bus_wdata", bus_wdata, 32'hABCD);
        check("sim_stall_if",  stallreq_if, 1);
        bus_ready = 1'b1; bus_rdata = 32'h55;
        @(negedge clk);
        check("sim_mem_done",  mem_done,  1);
        check("sim_mem_rdata", mem_rdata, 32'h55);
        check("sim_turnaround", bus_req,  0);
        bus_ready = 1'b0;
        @(negedge clk);
        check("sim_if_grant_req",  bus_req,  1);
        check("sim_if_grant_addr", bus_addr, 32'h200);
        check("sim_if_grant_we",   bus_we,   0);
        check("sim_if_grant_sel",  bus_sel,  4'hF);
        mem_req = 1'b0; mem_we = 1'b0;
        bus_ready = 1'b1; bus_rdata = 32'h11112222;
        @(negedge clk);
        check("sim_if_done",  if_done,  1);
        check("sim_if_rdata", if_rdata, 32'h11112222);
        bus_ready = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Starvation guard: IF drops only during MEM done cycles, so MEM keeps winning until the streak limit
        if_addr = 32'h300; mem_addr = 32'h2100; mem_sel = 4'hF; mem_we = 1'b0;
        ng = 0; if_seen = 1'b0;
        for (int c = 0; c < 40 && !(ng == 6 && mem_done); c++) begin
            @(negedge clk);
            if (bus_req) begin
                if (ng < 8) g[ng] = bus_addr;
                ng++;
            end
            bus_ready = bus_req;
            bus_rdata = 32'h1000 + c;
            if (if_done) if_seen = 1'b1;
            if_req  = if_seen ? 1'b0 : ~mem_done;
            mem_req = 1'b1;
        end
        mem_req = 1'b0; if_req = 1'b0; bus_ready = 1'b0;
        check("starve_grants", ng, 6);
        check("starve_g0", g[0], 32'h2100);
        check("starve_g1", g[1], 32'h2100);
        check("starve_g2", g[2], 32'h2100);
        check("starve_g3", g[3], 32'h2100);
        check("starve_g4_if", g[4], 32'h300);
        check("starve_g5_mem", g[5], 32'h2100);
        @(negedge clk);

        // Timeout with bus_ready never asserted
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h3000;
        bus_rdata = 32'hDEADBEEF; bus_ready = 1'b0;
        busy = 0; got_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_done) begin
                got_done = 1'b1;
                break;
            end
            if (bus_req) busy++;
        end
        check("to_done",        got_done,  1);
        check("to_busy_cycles", busy,      16);
        check("to_err",         bus_err,   1);
        check("to_rdata",       mem_rdata, 0);
        check("to_bus_req",     bus_req,   0);
        mem_req = 1'b0;
        @(negedge clk);
        check("to_err_pulse",  bus_err,  0);
        check("to_done_pulse", mem_done, 0);

        // Next request after the abort completes normally
        if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        check("post_to_addr", bus_addr, 32'h400);
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("post_to_done",  if_done,  1);
        check("post_to_rdata", if_rdata, 32'h0BADF00D);
        check("post_to_err",   bus_err,  0);
        bus_ready = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Ready arrives exactly on the abort-limit cycle
        mem_req = 1'b1; mem_addr = 32'h5000;
        busy = 0; got_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_done) begin
                got_done = 1'b1;
                break;
            end
            bus_ready = 1'b0;
            if (bus_req) begin
                busy++;
                if (busy == 16) begin
                    bus_ready = 1'b1;
                    bus_rdata = 32'h600D;
                end
            end
        end
        check("lim_done",  got_done,  1);
        check("lim_busy",  busy,      16);
        check("lim_err",   bus_err,   0);
        check("lim_rdata", mem_rdata, 32'h600D);
        bus_ready = 1'b0; mem_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a transaction
        if_req = 1'b1; if_addr = 32'h700;
        @(negedge clk);
        check("ar_pre_busy", bus_req, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_bus_req",   bus_req,   0);
        check("ar_bus_addr",  bus_addr,  0);
        check("ar_bus_sel",   bus_sel,   0);
        check("ar_if_rdata",  if_rdata,  0);
        check("ar_mem_rdata", mem_rdata, 0);
        check("ar_if_done",   if_done,   0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ar_regrant_req",  bus_req,  1);
        check("ar_regrant_addr", bus_addr, 32'h700);
        bus_ready = 1'b1; bus_rdata = 32'h77;
        @(negedge clk);
        check("ar_done",  if_done,  1);
        check("ar_rdata", if_rdata, 32'h77);
        bus_ready = 1'b0; if_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch port (IF, read-only) and the data port (MEM, loads and stores).
- Sequences one bus transaction at a time with a req/ready handshake and returns read data to the winning requester.
- Generates stall requests for the pipeline control block and aborts hung transactions with a timeout error.
- Sits between the IF/MEM stages and the external SRAM bus.

Parameters:
- TIMEOUT, 16: busy cycles allowed without bus_ready before abort; 0 disables the timeout.
- MEM_STREAK_MAX, 4: consecutive MEM grants allowed while if_req is pending before IF is forced a grant.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  instruction fetch request; held until if_done.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  data access request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  4  byte enables.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid while mem_done=1.
- mem_done  out  1  one-cycle completion pulse for MEM.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  bus write enable.
- bus_sel  out  4  bus byte enables.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  bus read data; sampled when bus_ready=1.
- bus_ready  in  1  transaction complete.
- stallreq_if  out  1  IF stage must stall.
- stallreq_mem  out  1  MEM stage must stall.
- bus_err  out  1  one-cycle pulse, coincident with done, on timeout abort.

Behaviour:
- Reset values (rst=0, asynchronous): state IDLE; bus_req, bus_we, if_done, mem_done, bus_err = 0; bus_sel = 0; bus_addr, bus_wdata, if_rdata, mem_rdata = 0; timeout counter = 0; streak counter = 0.
- States are IDLE, BUSY_IF and BUSY_MEM.
- IDLE arbitration:
  - A requester whose done output is currently 1 is ignored in that cycle. The request is still high during the done cycle; this rule blocks a double grant.
  - Eligible MEM wins, unless IF is also eligible and streak = MEM_STREAK_MAX; then IF wins.
  - Winner's address, we, sel and wdata are registered onto the bus. bus_req=1 from the next cycle. IF grants drive we=0 and sel=4'hF.
- Grant bookkeeping:
  - MEM grant with if_req pending: streak increments, saturating.
  - IF grant: streak clears.
  - MEM grant with no if_req pending: streak clears.
- BUSY_x with bus_ready=1:
  - bus_rdata is captured into x_rdata and x_done pulses for one cycle.
  - bus_req drops and the state returns to IDLE. There is always one IDLE turnaround cycle between transactions.
  - For a store, mem_rdata is captured anyway; the value is don't-care.
- Bus outputs stay constant throughout BUSY. Requester input changes during BUSY are ignored.
- Timeout:
  - The counter clears on entry to BUSY and increments each BUSY cycle without bus_ready.
  - When the counter reaches TIMEOUT-1 with bus_ready still 0 (i.e. TIMEOUT cycles with no ready), the transaction aborts. x_done=1, bus_err=1 and x_rdata=0 in the next cycle; bus_req drops; the state returns to IDLE.
  - bus_ready in the same cycle as the abort limit wins: normal completion, no error.
- Stalls (combinational): stallreq_if = if_req & ~if_done; stallreq_mem = mem_req & ~mem_done.
- Minimum latency: request seen in IDLE at cycle t, bus_req at t+1, ready at t+1 gives done at t+2.
- Reset asserted mid-transaction aborts immediately. There is no done pulse and bus_req falls asynchronously.

Test Plan:
- Lone IF read: if_req=1, addr=0x100; bus_ready one cycle after bus_req, bus_rdata=0x24010005 -> bus_addr=0x100, bus_we=0; if_done pulses 2 cycles after request with if_rdata=0x24010005; stallreq_if=1 until then.
- Simultaneous requests: if_req and mem_req (store, addr=0x2000, sel=0011, wdata=0xABCD) in the same cycle -> MEM granted first, bus_we=1, bus_sel=0011; IF granted after mem_done plus one IDLE cycle; no double grant during the done cycle.
- Starvation guard: mem_req re-raised continuously with if_req held, MEM_STREAK_MAX=4 -> exactly 4 MEM transactions, then IF granted, then streak=0.
- Timeout: TIMEOUT=16, bus_ready never asserted -> mem_done=1, bus_err=1, mem_rdata=0 in the cycle after the 16th BUSY cycle; bus_req low; next request serviced normally.
- Ready at the limit: bus_ready=1 exactly on the abort-limit cycle -> normal done with data, bus_err=0.
- Async reset mid-BUSY: rst=0 while bus_req=1 -> all outputs 0 immediately without a clock edge; after release, state is IDLE and the pending request is re-arbitrated.
